pkt_buf_passthrough: RTL and testbench
======================================

Name: pkt_buf_passthrough

Overview:
- Parametrised successor to the user-data-path passthrough stage.
- Inserts a show-ahead packet FIFO between the input and output data buses and honours out_rdy backpressure.
- Tracks packet and word statistics with a header/payload/EOP state machine.
- Serves those statistics on the register ring and forwards all other register requests one cycle later.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, control bus width.
- FIFO_DEPTH, 16, buffer depth in words; power of 2, at least 4.
- UDP_REG_SRC_WIDTH, 2, register source tag width.
- REG_ADDR_WIDTH, 16, register address width.
- REG_DATA_WIDTH, 16, register data width.
- REG_BLOCK_TAG, 1, block tag compared with reg_addr_in[REG_ADDR_WIDTH-1:4].
- COUNT_WIDTH, 32, statistics counter width; equals 2*REG_DATA_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input control.
- in_wr  in  1  input write strobe.
- in_rdy  out  1  block can accept a word this cycle.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- out_ctrl  out  CTRL_WIDTH  head-of-FIFO control.
- out_wr  out  1  output write strobe.
- out_rdy  in  1  downstream can accept a word.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  register ring request, ack and read/write-low.
- reg_addr_in  in  REG_ADDR_WIDTH  register address.
- reg_data_in  in  REG_DATA_WIDTH  register data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  register source tag.
- reg_*_out  out  same widths as the matching reg_*_in  registered ring outputs.

Behaviour:
- Reset: asynchronous, active-high; it overrides everything else, including a packet or register access in progress.
  - FIFO is emptied; in_rdy=1; out_wr=0; out_data=0; out_ctrl=0.
  - State machine goes to HDR.
  - pkt_cnt, word_cnt and the hi shadow register are cleared.
  - All reg_*_out are 0.
- Input side:
  - in_rdy = !full, decoded from registered occupancy.
  - A word is accepted only when in_wr && in_rdy.
  - in_wr while !in_rdy is ignored: no write, no count.
- Output side:
  - out_wr = !empty && out_rdy; out_data/out_ctrl always show the head entry.
  - A pop happens whenever out_wr=1.
  - Latency: a word accepted in cycle N can appear on out_wr in cycle N+1.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, a pop does not free in_rdy in the same cycle; in_rdy rises in the next cycle.
  - When empty, a push does not bypass; it leaves in the next cycle.
- Pointers: log2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Packet FSM, evaluated on accepted words only:
  - HDR: a word with ctrl!=0 stays in HDR (module header). A word with ctrl==0 goes to PAYLOAD.
  - PAYLOAD: a word with ctrl==0 stays in PAYLOAD. A word with ctrl!=0 is EOP: pkt_cnt+1, go to HDR.
- Counters:
  - word_cnt increments on every accepted word.
  - Both counters wrap at 2^COUNT_WIDTH and never saturate.
- Register ring, one-cycle registered path:
  - A hit is reg_req_in && !reg_ack_in && reg_addr_in[REG_ADDR_WIDTH-1:4]==REG_BLOCK_TAG.
  - Offsets: 0 PKT_LO, 1 PKT_HI, 2 WORD_LO, 3 WORD_HI.
  - Read of a *_LO offset returns the low half and latches the high half into the shadow in the same cycle. A read of the matching *_HI offset returns that shadow.
  - On a hit: reg_ack_out=1, and reg_data_out = the read value, or reg_data_in on a write. All other fields are copied from the inputs.
  - A hit on offsets 4-15 acks with reg_data_out=16'hDEAD.
  - A non-hit copies all inputs to the outputs unchanged, one cycle later.
- A counter increment in the same cycle as a LO read: the read returns the pre-increment value.

Optional Feature:
- Macro: PKT_BUF_STATS_CLEAR_EN.
- Defined: a write hit to offset 0 or 2 clears both counters and the shadow on the next edge. If a packet is accepted in that same cycle, the clear wins.
- Undefined: writes are acked and have no effect.

Decomposition:
- Package pkt_buf_pkg holds:
  - state encoding HDR=1'b0, PAYLOAD=1'b1;
  - register offset constants PKT_LO/PKT_HI/WORD_LO/WORD_HI;
  - the bad-address value 16'hDEAD.
- One sub-module, pkt_buf_fifo: show-ahead synchronous FIFO with DATA+CTRL width, full/empty flags and occupancy output.

Test Plan:
- Two-header, three-payload packet with ctrl 0xFF,0xFF,0,0,0x40 and out_rdy=1:
  - output order is identical, each word one cycle later;
  - pkt_cnt=1, word_cnt=5.
- out_rdy=0 while writing 16 words with FIFO_DEPTH=16:
  - in_rdy falls after the 16th word;
  - a 17th in_wr is ignored and word_cnt stays 16;
  - after out_rdy=1 for 1 cycle, in_rdy=1 in the following cycle.
- Read PKT_LO then PKT_HI at pkt_cnt=0x0001FFFF, with a packet completing between the two reads:
  - returns 0xFFFF, then 0x0001 (the shadow).
- Non-matching tag request:
  - all reg_*_out equal the inputs one cycle later;
  - a matching request with reg_ack_in=1 is also forwarded unchanged.
- Assert reset mid-packet with the FIFO holding 5 words:
  - out_wr=0 immediately;
  - counters read 0 afterwards;
  - the next packet is counted from HDR.
- With PKT_BUF_STATS_CLEAR_EN, write offset 0:
  - next read of PKT_LO and WORD_LO both return 0;
  - without the macro, both keep their prior values.

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the packet-buffer passthrough stage.
// Holds the packet FSM encoding and the statistics register map.
package pkt_buf_pkg;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [3:0] PKT_LO  = 4'd0;
    localparam logic [3:0] PKT_HI  = 4'd1;
    localparam logic [3:0] WORD_LO = 4'd2;
    localparam logic [3:0] WORD_HI = 4'd3;

    localparam logic [15:0] BAD_ADDR_DATA = 16'hDEAD;

endpackage

// File: rtl/pkt_buf_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always on rd_data.
// Full/empty are decoded from a registered occupancy counter.
module pkt_buf_fifo
    import pkt_buf_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly AW bits so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_buf_passthrough.sv
// Buffered data-path passthrough with packet/word statistics on the reg ring.
// Define PKT_BUF_STATS_CLEAR_EN to let a write to PKT_LO/WORD_LO clear stats.
module pkt_buf_passthrough
    import pkt_buf_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH        = 16,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int REG_ADDR_WIDTH    = 16,
    parameter int REG_DATA_WIDTH    = 16,
    parameter int REG_BLOCK_TAG     = 1,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,

    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,

    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0]    reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0]    reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = REG_ADDR_WIDTH - 4;
    localparam int DW = REG_DATA_WIDTH;
    localparam int FW = DATA_WIDTH + CTRL_WIDTH;

    localparam logic [TW-1:0] TAG = TW'(REG_BLOCK_TAG);
    localparam logic [DW-1:0] BAD = DW'(BAD_ADDR_DATA);

    logic          full;
    logic          empty;
    logic [AW:0]   occ;
    logic          unused_occ;
    logic [FW-1:0] head;

    logic          accept;
    logic          is_ctrl;
    logic          pkt_done;
    state_t        state;
    state_t        state_nxt;

    logic [COUNT_WIDTH-1:0] pkt_cnt;
    logic [COUNT_WIDTH-1:0] word_cnt;
    logic [DW-1:0]          shadow;

    logic          hit;
    logic [3:0]    ofs;
    logic          lo_read;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] hi_val;
    logic [DW-1:0] hit_data;
    logic          clr;

    pkt_buf_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data ({in_ctrl, in_data}),
        .wr_en   (in_wr),
        .rd_en   (out_rdy),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (occ)
    );

    assign unused_occ = ^occ;

    assign in_rdy   = !full;
    assign out_wr   = !empty && out_rdy;
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_ctrl = head[FW-1:DATA_WIDTH];

    assign accept  = in_wr && in_rdy;
    assign is_ctrl = (in_ctrl != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Header words (ctrl!=0) before any payload keep us in HDR.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            unique case (state)
                HDR:     if (!is_ctrl) state_nxt = PAYLOAD;
                PAYLOAD: if (is_ctrl)  state_nxt = HDR;
            endcase
        end
    end

    always_comb begin
        pkt_done = accept && (state == PAYLOAD) && is_ctrl;
    end

    assign ofs = reg_addr_in[3:0];
    assign hit = reg_req_in && !reg_ack_in &&
                 (reg_addr_in[REG_ADDR_WIDTH-1:4] == TAG);

    always_comb begin
        rd_val  = BAD;
        hi_val  = '0;
        lo_read = 1'b0;
        case (ofs)
            PKT_LO: begin
                rd_val  = pkt_cnt[DW-1:0];
                hi_val  = pkt_cnt[COUNT_WIDTH-1:DW];
                lo_read = 1'b1;
            end
            WORD_LO: begin
                rd_val  = word_cnt[DW-1:0];
                hi_val  = word_cnt[COUNT_WIDTH-1:DW];
                lo_read = 1'b1;
            end
            PKT_HI, WORD_HI: rd_val = shadow;
            default: rd_val = BAD;
        endcase
    end

    always_comb begin
        if (ofs > WORD_HI) begin
            hit_data = BAD;
        end else if (reg_rd_wr_L_in) begin
            hit_data = rd_val;
        end else begin
            hit_data = reg_data_in;
        end
    end

`ifdef PKT_BUF_STATS_CLEAR_EN
    assign clr = hit && !reg_rd_wr_L_in &&
                 ((ofs == PKT_LO) || (ofs == WORD_LO));
`else
    assign clr = 1'b0;
`endif

    // A clear takes priority over any increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= '0;
            word_cnt <= '0;
            shadow   <= '0;
        end else if (clr) begin
            pkt_cnt  <= '0;
            word_cnt <= '0;
            shadow   <= '0;
        end else begin
            if (pkt_done) pkt_cnt  <= pkt_cnt + 1'b1;
            if (accept)   word_cnt <= word_cnt + 1'b1;
            if (hit && reg_rd_wr_L_in && lo_read) shadow <= hi_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in || hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= hit ? hit_data : reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end

endmodule

// File: tb/tb_pkt_buf_passthrough.sv
// Directed self-checking bench for pkt_buf_passthrough.
// Expected register values follow PKT_BUF_STATS_CLEAR_EN when defined.
module tb_pkt_buf_passthrough;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b0;

    logic        reg_req_in = 1'b0;
    logic        reg_ack_in = 1'b0;
    logic        reg_rd_wr_L_in = 1'b0;
    logic [15:0] reg_addr_in = '0;
    logic [15:0] reg_data_in = '0;
    logic [1:0]  reg_src_in = '0;
    logic        reg_req_out;
    logic        reg_ack_out;
    logic        reg_rd_wr_L_out;
    logic [15:0] reg_addr_out;
    logic [15:0] reg_data_out;
    logic [1:0]  reg_src_out;

    int n_chk = 0;
    int n_pass = 0;

    pkt_buf_passthrough dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_wr          (out_wr),
        .out_rdy         (out_rdy),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] c, input logic [63:0] d);
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        tick;
        in_wr   = 1'b0;
        in_ctrl = '0;
        in_data = '0;
    endtask

    task automatic reg_acc(input logic rd, input logic [15:0] addr,
                           input logic [15:0] wdata,
                           output logic [15:0] rdata, output logic ack);
        reg_req_in     = 1'b1;
        reg_ack_in     = 1'b0;
        reg_rd_wr_L_in = rd;
        reg_addr_in    = addr;
        reg_data_in    = wdata;
        reg_src_in     = 2'd1;
        tick;
        rdata = reg_data_out;
        ack   = reg_ack_out;
        reg_req_in     = 1'b0;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in    = '0;
        reg_data_in    = '0;
        reg_src_in     = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr,
                          input logic [15:0] exp);
        logic [15:0] d;
        logic        a;
        reg_acc(1'b1, addr, 16'h0, d, a);
        chk({tag, "_ack"}, 128'(a), 128'(1'b1));
        chk(tag, 128'(d), 128'(exp));
    endtask

    function automatic logic [36:0] reg_out_bus();
        return {reg_req_out, reg_ack_out, reg_rd_wr_L_out,
                reg_addr_out, reg_data_out, reg_src_out};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  c1 [5];
        logic [15:0] d;
        logic        a;
        logic [15:0] exp_pkt;
        logic [15:0] exp_word;

        c1 = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h40};

        // reset state
        out_rdy = 1'b1;
        tick;
        tick;
        chk("rst_in_rdy", 128'(in_rdy), 128'(1'b1));
        chk("rst_out_wr", 128'(out_wr), 128'(1'b0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_reg_out", 128'(reg_out_bus()), 128'(0));
        reset = 1'b0;

        // five-word packet streamed with out_rdy high
        for (int i = 0; i < 5; i++) begin
            in_wr   = 1'b1;
            in_ctrl = c1[i];
            in_data = 64'hA0A0_0000_0000_0000 | 64'(i);
            tick;
            chk("t1_out_wr", 128'(out_wr), 128'(1'b1));
            chk("t1_out_data", 128'(out_data),
                128'(64'hA0A0_0000_0000_0000 | 64'(i)));
            chk("t1_out_ctrl", 128'(out_ctrl), 128'(c1[i]));
        end
        in_wr = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        tick;
        chk("t1_drained", 128'(out_wr), 128'(1'b0));
        rd_chk("t1_pkt_lo", 16'h0010, 16'd1);
        rd_chk("t1_word_lo", 16'h0012, 16'd5);
        rd_chk("t1_word_hi", 16'h0013, 16'd0);

        // fill with backpressure
        pulse_reset;
        out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t2_in_rdy_fill", 128'(in_rdy), 128'(1'b1));
            push(8'h00, 64'hB000 + 64'(i));
        end
        chk("t2_full", 128'(in_rdy), 128'(1'b0));
        push(8'h00, 64'hDEAD);
        chk("t2_still_full", 128'(in_rdy), 128'(1'b0));
        rd_chk("t2_word_lo", 16'h0012, 16'd16);
        out_rdy = 1'b1;
        #1;
        chk("t2_pop_wr", 128'(out_wr), 128'(1'b1));
        chk("t2_pop_data", 128'(out_data), 128'(64'hB000));
        chk("t2_rdy_same_cycle", 128'(in_rdy), 128'(1'b0));
        tick;
        out_rdy = 1'b0;
        #1;
        chk("t2_rdy_next", 128'(in_rdy), 128'(1'b1));
        chk("t2_head_next", 128'(out_data), 128'(64'hB001));

        // LO/HI shadow across a wrap of the low half
        pulse_reset;
        out_rdy = 1'b1;
        push(8'h00, 64'h1);
        force dut.pkt_cnt = 32'h0001_FFFF;
        tick;
        release dut.pkt_cnt;
        rd_chk("t3_pkt_lo", 16'h0010, 16'hFFFF);
        push(8'h01, 64'h2);
        rd_chk("t3_pkt_hi", 16'h0011, 16'h0001);
        rd_chk("t3_pkt_lo2", 16'h0010, 16'h0000);
        rd_chk("t3_pkt_hi2", 16'h0011, 16'h0002);
        push(8'h00, 64'h3);
        in_wr = 1'b1;
        in_ctrl = 8'h02;
        in_data = 64'h4;
        rd_chk("t3_pre_inc", 16'h0010, 16'h0000);
        in_wr = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        rd_chk("t3_post_inc", 16'h0010, 16'h0001);

        // ring forwarding
        reg_req_in = 1'b1;
        reg_ack_in = 1'b0;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in = 16'h0230;
        reg_data_in = 16'hBEEF;
        reg_src_in = 2'd2;
        tick;
        chk("t4_miss_fwd", 128'(reg_out_bus()),
            128'({1'b1, 1'b0, 1'b0, 16'h0230, 16'hBEEF, 2'd2}));
        reg_ack_in = 1'b1;
        reg_rd_wr_L_in = 1'b1;
        reg_addr_in = 16'h0010;
        reg_data_in = 16'h1234;
        reg_src_in = 2'd3;
        tick;
        chk("t4_acked_fwd", 128'(reg_out_bus()),
            128'({1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234, 2'd3}));
        reg_ack_in = 1'b0;
        reg_addr_in = 16'h0017;
        reg_data_in = 16'h7777;
        reg_src_in = 2'd1;
        tick;
        chk("t4_bad_ofs", 128'(reg_out_bus()),
            128'({1'b1, 1'b1, 1'b1, 16'h0017, 16'hDEAD, 2'd1}));
        reg_req_in = 1'b0;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0;
        reg_data_in = '0;
        reg_src_in = '0;
        tick;
        chk("t4_idle", 128'(reg_out_bus()), 128'(0));

        // reset mid-packet
        pulse_reset;
        out_rdy = 1'b0;
        push(8'hFF, 64'hC0);
        for (int i = 1; i < 5; i++) push(8'h00, 64'hC0 + 64'(i));
        out_rdy = 1'b1;
        #1;
        chk("t5_pre_wr", 128'(out_wr), 128'(1'b1));
        chk("t5_pre_data", 128'(out_data), 128'(64'hC0));
        reset = 1'b1;
        #1;
        chk("t5_rst_wr", 128'(out_wr), 128'(1'b0));
        chk("t5_rst_rdy", 128'(in_rdy), 128'(1'b1));
        chk("t5_rst_data", 128'(out_data), 128'(0));
        tick;
        reset = 1'b0;
        rd_chk("t5_pkt_lo0", 16'h0010, 16'd0);
        rd_chk("t5_word_lo0", 16'h0012, 16'd0);
        push(8'hFF, 64'hD0);
        push(8'h00, 64'hD1);
        push(8'h04, 64'hD2);
        rd_chk("t5_pkt_lo", 16'h0010, 16'd1);
        rd_chk("t5_word_lo", 16'h0012, 16'd3);

        // write to PKT_LO
`ifdef PKT_BUF_STATS_CLEAR_EN
        exp_pkt = 16'd0;
        exp_word = 16'd0;
`else
        exp_pkt = 16'd1;
        exp_word = 16'd3;
`endif
        reg_acc(1'b0, 16'h0010, 16'h5555, d, a);
        chk("t6_wr_ack", 128'(a), 128'(1'b1));
        chk("t6_wr_data", 128'(d), 128'(16'h5555));
        rd_chk("t6_pkt_lo", 16'h0010, exp_pkt);
        rd_chk("t6_word_lo", 16'h0012, exp_word);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
